// File: rtl/pll40_ctrl_pkg.sv
// Shared types and helpers for the SB_PLL40 lock sequencer: state encoding,
// counter sizing and the registered output bundle decoded from each state.
package pll40_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_LOCKED    = 3'd2,
    ST_FAIL      = 3'd3,
    ST_SLEEP     = 3'd4
  } state_t;

  localparam logic [7:0] LOSS_CNT_MAX = 8'hFF;

  typedef struct packed {
    logic resetb;
    logic bypass;
    logic ready;
    logic cfg_ready;
    logic fail;
    logic latch;
    logic sleep_ack;
  } pll_out_t;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Every status output is a pure function of the state being entered.
  function automatic pll_out_t decode_outputs(input state_t st);
    pll_out_t o;
    o = '0;
    case (st)
      ST_RESET: begin
        o.bypass = 1'b1;
      end
      ST_WAIT_LOCK: begin
        o.resetb = 1'b1;
        o.bypass = 1'b1;
      end
      ST_LOCKED: begin
        o.resetb    = 1'b1;
        o.ready     = 1'b1;
        o.cfg_ready = 1'b1;
      end
      ST_FAIL: begin
        o.bypass    = 1'b1;
        o.fail      = 1'b1;
        o.cfg_ready = 1'b1;
      end
      ST_SLEEP: begin
        o.resetb    = 1'b1;
        o.latch     = 1'b1;
        o.sleep_ack = 1'b1;
      end
      default: begin
        o.bypass = 1'b1;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pll40_lock_sync.sv
// Multi-flop synchroniser for the asynchronous PLL LOCK output, cleared by
// the asynchronous controller reset.
module pll40_lock_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] stage_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= {stage_reg[STAGES-2:0], din};
    end
  end

  assign dout = stage_reg[STAGES-1];

endmodule

// File: rtl/pll40_lock_ctrl.sv
// SB_PLL40 reset/lock sequencer running on the reference clock.
// Optional PLL40_CTRL_ICEGATE_EN adds a SLEEP state driving LATCHINPUTVALUE.
module pll40_lock_ctrl
  import pll40_ctrl_pkg::*;
#(
  parameter int         RESET_CYCLES = 16,
  parameter int         LOCK_STABLE  = 64,
  parameter int         LOCK_TIMEOUT = 4096,
  parameter int         LOSS_FILTER  = 4,
  parameter int         MAX_RETRY    = 3,
  parameter logic [7:0] DELAY_INIT   = 8'h00
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pll_lock_i,
  output logic                           pll_resetb_o,
  output logic                           pll_bypass_o,
  output logic [7:0]                     pll_dyndelay_o,
  output logic                           pll_latch_o,
  input  logic                           cfg_valid,
  input  logic [7:0]                     cfg_delay,
  output logic                           cfg_ready,
  output logic                           ready,
  output logic                           fail,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
  output logic [7:0]                     loss_cnt,
  input  logic                           sleep_req,
  output logic                           sleep_ack
);

  localparam int TMAX = (LOCK_TIMEOUT > RESET_CYCLES) ? LOCK_TIMEOUT : RESET_CYCLES;
  localparam int TW   = cnt_width(TMAX);
  localparam int SW   = cnt_width(LOCK_STABLE);
  localparam int LW   = cnt_width(LOSS_FILTER);
  localparam int RW   = $clog2(MAX_RETRY + 1);

  localparam logic [TW-1:0] RESET_LAST   = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STABLE_LAST  = SW'(LOCK_STABLE - 1);
  localparam logic [LW-1:0] LOSS_LAST    = LW'(LOSS_FILTER - 1);
  localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRY - 1);

  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [SW-1:0]   stable_reg, stable_next;
  logic [LW-1:0]   loss_reg, loss_next;
  logic [RW-1:0]   retry_reg, retry_next;
  logic [7:0]      losscnt_reg, losscnt_next;
  logic [7:0]      delay_reg, delay_next;
  pll_out_t        out_reg;
  logic            lock_s;
  logic            accept;
  logic            sleep_go;

  pll40_lock_sync #(.STAGES(2)) u_lock_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (pll_lock_i),
    .dout (lock_s)
  );

`ifdef PLL40_CTRL_ICEGATE_EN
  assign sleep_go    = sleep_req;
  assign pll_latch_o = out_reg.latch;
  assign sleep_ack   = out_reg.sleep_ack;
`else
  logic unused_sleep_bits;
  assign sleep_go          = 1'b0;
  assign unused_sleep_bits = sleep_req ^ out_reg.latch ^ out_reg.sleep_ack;
  assign pll_latch_o       = 1'b0;
  assign sleep_ack         = 1'b0;
`endif

  assign accept = cfg_valid & out_reg.cfg_ready;

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    stable_next  = stable_reg;
    loss_next    = loss_reg;
    retry_next   = retry_reg;
    losscnt_next = losscnt_reg;
    delay_next   = delay_reg;
    case (state_reg)
      ST_RESET: begin
        if (timer_reg == RESET_LAST) begin
          state_next  = ST_WAIT_LOCK;
          timer_next  = '0;
          stable_next = '0;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        timer_next  = timer_reg + 1'b1;
        stable_next = lock_s ? stable_reg + 1'b1 : '0;
        // A lock qualifying on the timeout cycle still counts as a lock.
        if (lock_s && (stable_reg == STABLE_LAST)) begin
          state_next = ST_LOCKED;
          retry_next = '0;
          loss_next  = '0;
          timer_next = '0;
        end else if (timer_reg == TIMEOUT_LAST) begin
          retry_next = retry_reg + 1'b1;
          timer_next = '0;
          state_next = (retry_reg == RETRY_LAST) ? ST_FAIL : ST_RESET;
        end
      end
      ST_LOCKED: begin
        if (accept) begin
          delay_next = cfg_delay;
          retry_next = '0;
          timer_next = '0;
          loss_next  = '0;
          state_next = ST_RESET;
        end else if (sleep_go) begin
          state_next = ST_SLEEP;
        end else if (lock_s) begin
          loss_next = '0;
        end else if (loss_reg == LOSS_LAST) begin
          loss_next  = '0;
          timer_next = '0;
          state_next = ST_RESET;
          if (losscnt_reg != LOSS_CNT_MAX) begin
            losscnt_next = losscnt_reg + 1'b1;
          end
        end else begin
          loss_next = loss_reg + 1'b1;
        end
      end
      ST_FAIL: begin
        if (accept) begin
          delay_next = cfg_delay;
          retry_next = '0;
          timer_next = '0;
          state_next = ST_RESET;
        end
      end
      ST_SLEEP: begin
        // Wake straight into lock qualification; RESETB stays high.
        if (!sleep_go) begin
          state_next  = ST_WAIT_LOCK;
          timer_next  = '0;
          stable_next = '0;
        end
      end
      default: begin
        state_next = ST_RESET;
        timer_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_RESET;
      timer_reg   <= '0;
      stable_reg  <= '0;
      loss_reg    <= '0;
      retry_reg   <= '0;
      losscnt_reg <= '0;
      delay_reg   <= DELAY_INIT;
      out_reg     <= decode_outputs(ST_RESET);
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      stable_reg  <= stable_next;
      loss_reg    <= loss_next;
      retry_reg   <= retry_next;
      losscnt_reg <= losscnt_next;
      delay_reg   <= delay_next;
      out_reg     <= decode_outputs(state_next);
    end
  end

  assign pll_resetb_o   = out_reg.resetb;
  assign pll_bypass_o   = out_reg.bypass;
  assign pll_dyndelay_o = delay_reg;
  assign cfg_ready      = out_reg.cfg_ready;
  assign ready          = out_reg.ready;
  assign fail           = out_reg.fail;
  assign retry_cnt      = retry_reg;
  assign loss_cnt       = losscnt_reg;

endmodule

// File: tb/tb_pll40_lock_ctrl.sv
// Bench for pll40_lock_ctrl: directed lock/loss/timeout/config scenarios, then
// randomized LOCK, config and sleep traffic against a behavioural model.
module tb_pll40_lock_ctrl;

  localparam int         RC = 16;
  localparam int         LS = 64;
  localparam int         LT = 256;
  localparam int         LF = 4;
  localparam int         MR = 3;
  localparam logic [7:0] DI = 8'h00;
`ifdef PLL40_CTRL_ICEGATE_EN
  localparam bit ICE = 1'b1;
`else
  localparam bit ICE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock_i = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_delay = 8'h00;
  logic       sleep_req = 1'b0;
  logic       pll_resetb_o, pll_bypass_o, pll_latch_o;
  logic [7:0] pll_dyndelay_o;
  logic       cfg_ready, ready, fail, sleep_ack;
  logic [1:0] retry_cnt;
  logic [7:0] loss_cnt;

  always #5 clk = ~clk;

  pll40_lock_ctrl #(
    .RESET_CYCLES (RC),
    .LOCK_STABLE  (LS),
    .LOCK_TIMEOUT (LT),
    .LOSS_FILTER  (LF),
    .MAX_RETRY    (MR),
    .DELAY_INIT   (DI)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pll_lock_i     (pll_lock_i),
    .pll_resetb_o   (pll_resetb_o),
    .pll_bypass_o   (pll_bypass_o),
    .pll_dyndelay_o (pll_dyndelay_o),
    .pll_latch_o    (pll_latch_o),
    .cfg_valid      (cfg_valid),
    .cfg_delay      (cfg_delay),
    .cfg_ready      (cfg_ready),
    .ready          (ready),
    .fail           (fail),
    .retry_cnt      (retry_cnt),
    .loss_cnt       (loss_cnt),
    .sleep_req      (sleep_req),
    .sleep_ack      (sleep_ack)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Behavioural model: phase plus run-length bookkeeping in plain integers.
  localparam int M_RESET = 0, M_WAIT = 1, M_LOCKED = 2, M_FAIL = 3, M_SLEEP = 4;
  int         m_phase, m_age, m_high, m_low, m_retry, m_loss;
  logic [7:0] m_delay;
  bit         m_acc;
  bit         m_q[$];

  function void model_reset();
    m_phase = M_RESET;
    m_age   = 0;
    m_high  = 0;
    m_low   = 0;
    m_retry = 0;
    m_loss  = 0;
    m_delay = DI;
    m_acc   = 1'b0;
    m_q     = {1'b0, 1'b0};
  endfunction

  function void enter(input int p);
    m_phase = p;
    m_age   = 0;
    m_high  = 0;
    m_low   = 0;
  endfunction

  function void model_step();
    bit ls;
    ls = m_q.pop_front();
    m_q.push_back(pll_lock_i);
    m_acc = cfg_valid && (m_phase == M_LOCKED || m_phase == M_FAIL);
    if (m_acc) begin
      m_delay = cfg_delay;
      m_retry = 0;
      enter(M_RESET);
      return;
    end
    case (m_phase)
      M_RESET: begin
        m_age++;
        if (m_age == RC) enter(M_WAIT);
      end
      M_WAIT: begin
        m_age++;
        m_high = ls ? m_high + 1 : 0;
        if (m_high == LS) begin
          m_retry = 0;
          enter(M_LOCKED);
        end else if (m_age == LT) begin
          m_retry++;
          enter((m_retry == MR) ? M_FAIL : M_RESET);
        end
      end
      M_LOCKED: begin
        if (ICE && sleep_req) begin
          enter(M_SLEEP);
        end else begin
          m_low = ls ? 0 : m_low + 1;
          if (m_low == LF) begin
            if (m_loss < 255) m_loss++;
            enter(M_RESET);
          end
        end
      end
      M_SLEEP: begin
        if (!sleep_req) enter(M_WAIT);
      end
      default: ;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("resetb",   32'(pll_resetb_o), 32'(m_phase == M_WAIT || m_phase == M_LOCKED || m_phase == M_SLEEP));
    chk("bypass",   32'(pll_bypass_o), 32'(m_phase == M_RESET || m_phase == M_WAIT || m_phase == M_FAIL));
    chk("ready",    32'(ready),        32'(m_phase == M_LOCKED));
    chk("cfgrdy",   32'(cfg_ready),    32'(m_phase == M_LOCKED || m_phase == M_FAIL));
    chk("fail",     32'(fail),         32'(m_phase == M_FAIL));
    chk("latch",    32'(pll_latch_o),  32'(m_phase == M_SLEEP));
    chk("sleepack", 32'(sleep_ack),    32'(m_phase == M_SLEEP));
    chk("dyndelay", 32'(pll_dyndelay_o), 32'(m_delay));
    chk("retry",    32'(retry_cnt),    32'(m_retry));
    chk("losscnt",  32'(loss_cnt),     32'(m_loss));
  endtask

  task automatic check_reset_literal();
    chk("rst_resetb", 32'(pll_resetb_o), 32'd0);
    chk("rst_bypass", 32'(pll_bypass_o), 32'd1);
    chk("rst_delay",  32'(pll_dyndelay_o), 32'(DI));
    chk("rst_latch",  32'(pll_latch_o), 32'd0);
    chk("rst_cfgrdy", 32'(cfg_ready), 32'd0);
    chk("rst_ready",  32'(ready), 32'd0);
    chk("rst_fail",   32'(fail), 32'd0);
    chk("rst_ack",    32'(sleep_ack), 32'd0);
    chk("rst_retry",  32'(retry_cnt), 32'd0);
    chk("rst_loss",   32'(loss_cnt), 32'd0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return pll_resetb_o;
      1:       return ready;
      default: return fail;
    endcase
  endfunction

  task automatic run_until(input int w, input logic val, input int bound, input string nm,
                           output int n);
    n = 0;
    while (sig(w) !== val && n < bound) begin
      cycle();
      n++;
    end
    if (sig(w) !== val) chk({nm, "_timeout"}, 32'(sig(w)), 32'(val));
  endtask

  initial begin
    int n;
    int seg;
    int lows;
    model_reset();
    #12;
    check_reset_literal();
    rst = 1'b0;

    // Clean lock: RESETB after RC cycles, ready 66 cycles after raw LOCK.
    run_until(0, 1'b1, 100, "resetb_rise", n);
    chk("resetb_rise_cycles", 32'(n), 32'd16);
    repeat (20) cycle();
    pll_lock_i = 1'b1;
    run_until(1, 1'b1, 200, "clean_lock", n);
    chk("lock_latency", 32'(n), 32'd66);
    chk("lock_retry", 32'(retry_cnt), 32'd0);
    chk("lock_bypass", 32'(pll_bypass_o), 32'd0);

    // Lock loss: 3 low cycles ignored, 4 qualify.
    pll_lock_i = 1'b0;
    repeat (3) cycle();
    pll_lock_i = 1'b1;
    repeat (10) cycle();
    chk("short_drop_ready", 32'(ready), 32'd1);
    chk("short_drop_loss", 32'(loss_cnt), 32'd0);
    pll_lock_i = 1'b0;
    run_until(1, 1'b0, 20, "loss", n);
    chk("loss_latency", 32'(n), 32'd6);
    chk("loss_count", 32'(loss_cnt), 32'd1);
    chk("loss_resetb", 32'(pll_resetb_o), 32'd0);

    // Glitchy lock restarts the stable count.
    run_until(0, 1'b1, 100, "glitch_resetb", n);
    pll_lock_i = 1'b1;
    repeat (30) cycle();
    pll_lock_i = 1'b0;
    cycle();
    pll_lock_i = 1'b1;
    run_until(1, 1'b1, 200, "glitch_lock", n);
    chk("glitch_latency", 32'(n), 32'd66);

    // Config in LOCKED, then a held request ignored while relocking.
    cfg_valid = 1'b1;
    cfg_delay = 8'hC3;
    cycle();
    chk("cfg_delay_c3", 32'(pll_dyndelay_o), 32'hC3);
    chk("cfg_ready_drop", 32'(ready), 32'd0);
    chk("cfg_resetb_drop", 32'(pll_resetb_o), 32'd0);
    cfg_delay = 8'h77;
    run_until(0, 1'b1, 100, "cfg_resetb", n);
    repeat (5) cycle();
    chk("cfg_wait_rdy", 32'(cfg_ready), 32'd0);
    chk("cfg_wait_delay", 32'(pll_dyndelay_o), 32'hC3);
    cfg_valid = 1'b0;
    run_until(1, 1'b1, 200, "cfg_relock", n);

    // Timeouts: three retries then FAIL; a config accept leaves FAIL.
    pll_lock_i = 1'b0;
    run_until(2, 1'b1, 2000, "to_fail", n);
    chk("fail_cycles", 32'(n), 32'd822);
    chk("fail_retry", 32'(retry_cnt), 32'd3);
    chk("fail_cfgrdy", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_delay = 8'h5A;
    cycle();
    cfg_valid = 1'b0;
    chk("fail_cfg_delay", 32'(pll_dyndelay_o), 32'h5A);
    chk("fail_cleared", 32'(fail), 32'd0);
    chk("fail_retry_clr", 32'(retry_cnt), 32'd0);
    chk("fail_resetb", 32'(pll_resetb_o), 32'd0);

`ifdef PLL40_CTRL_ICEGATE_EN
    pll_lock_i = 1'b1;
    run_until(1, 1'b1, 400, "ice_lock", n);
    sleep_req = 1'b1;
    cycle();
    chk("ice_latch", 32'(pll_latch_o), 32'd1);
    chk("ice_ack", 32'(sleep_ack), 32'd1);
    chk("ice_ready", 32'(ready), 32'd0);
    sleep_req = 1'b0;
    n = 0;
    lows = 0;
    while (ready !== 1'b1 && n < 200) begin
      cycle();
      n++;
      if (pll_resetb_o !== 1'b1) lows++;
    end
    chk("ice_relock_cycles", 32'(n), 32'(LS + 1));
    chk("ice_resetb_pulse", 32'(lows), 32'd0);
`endif

    // Randomized traffic.
    seg = 0;
    for (int i = 0; i < 8000; i++) begin
      if (seg == 0) begin
        pll_lock_i = ~pll_lock_i;
        if (pll_lock_i) seg = int'($urandom_range(20, 400));
        else if ($urandom_range(0, 3) == 0) seg = int'($urandom_range(100, 700));
        else seg = int'($urandom_range(1, 6));
      end
      seg--;
      if ($urandom_range(0, 99) == 0) sleep_req = ~sleep_req;
      if (!cfg_valid && $urandom_range(0, 299) == 0) begin
        cfg_valid = 1'b1;
        cfg_delay = 8'($urandom);
      end
      cycle();
      if (m_acc) cfg_valid = 1'b0;
      if ($urandom_range(0, 2999) == 0) begin
        rst = 1'b1;
        #1;
        check_reset_literal();
        model_reset();
        #1;
        rst = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
